// File: rtl/blt_pkg.sv
// blt_pkg: shared constants, state encoding and frame builder for backlight_out_tx.
// BLT_PARITY_EN appends an even-parity bit, widening FRAME_W by one.
package blt_pkg;
  localparam int ADDR_W = 4;
  localparam int ZONES = 3;
  localparam int ZONE_W = 8;
  localparam int DUTY_W = ZONES * ZONE_W;
  localparam int DATA_W = ADDR_W + DUTY_W;
`ifdef BLT_PARITY_EN
  localparam int FRAME_W = DATA_W + 1;
`else
  localparam int FRAME_W = DATA_W;
`endif

  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, LATCH, GAP} state_t;

  function automatic logic [FRAME_W-1:0] make_frame(input logic [DATA_W-1:0] d);
`ifdef BLT_PARITY_EN
    return {d, ^d};
`else
    return d;
`endif
  endfunction
endpackage

// File: rtl/blt_sclk_div.sv
// blt_sclk_div: half-period counter producing SCLK and a falling-edge tick while enabled.
module blt_sclk_div #(
  parameter int CLK_DIV = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  output logic o_sclk,
  output logic o_fall
);
  localparam logic [7:0] LAST = 8'(CLK_DIV - 1);

  logic [7:0] r_cnt;
  logic       r_sclk;
  logic       w_tick;

  assign w_tick = i_en & (r_cnt == LAST);
  assign o_sclk = r_sclk;
  assign o_fall = w_tick & r_sclk;

  // counter restarts at zero each time SHIFT is entered, so the first half-period is always low
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt  <= '0;
      r_sclk <= 1'b0;
    end else if (!i_en) begin
      r_cnt  <= '0;
      r_sclk <= 1'b0;
    end else begin
      r_cnt  <= w_tick ? '0 : r_cnt + 8'd1;
      r_sclk <= r_sclk ^ w_tick;
    end
  end
endmodule

// File: rtl/backlight_out_tx.sv
// backlight_out_tx: serialises {row address, duty} frames MSB first over SCLK/SDI/LATCH.
// One-deep pending buffer; BLT_PARITY_EN appends an even-parity bit to each frame.
module backlight_out_tx
  import blt_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int GAP_CYC = 8
) (
  input  logic              iODCK,
  input  logic              iRST_n,
  input  logic              iOU_en,
  input  logic [ADDR_W-1:0] iV_Address,
  input  logic [DUTY_W-1:0] iH_Duty,
  input  logic              iClrErr,
  output logic              oSCLK,
  output logic              oSDI,
  output logic              oLATCH,
  output logic              oBusy,
  output logic              oOverflow
);
  localparam int BIT_W = $clog2(FRAME_W);
  localparam logic [15:0] LATCH_LAST = 16'(2 * CLK_DIV - 1);
  localparam logic [15:0] GAP_LAST = 16'(GAP_CYC - 1);

  state_t             r_state, w_state_n;
  logic [DATA_W-1:0]  r_pend;
  logic               r_pend_v, r_sdi, r_ovf;
  logic [FRAME_W-1:0] r_shift, w_frame;
  logic [BIT_W-1:0]   r_bit;
  logic [15:0]        r_cnt;
  logic               w_fall, w_start, w_pend_wr, w_drop;

  blt_sclk_div #(.CLK_DIV(CLK_DIV)) u_div (
    .i_clk  (iODCK),
    .i_rst_n(iRST_n),
    .i_en   (r_state == SHIFT),
    .o_sclk (oSCLK),
    .o_fall (w_fall)
  );

  always_comb begin
    w_state_n = r_state;
    case (r_state)
      IDLE:    w_state_n = (iOU_en | r_pend_v) ? LOAD : IDLE;
      LOAD:    w_state_n = SHIFT;
      SHIFT:   w_state_n = (w_fall && r_bit == '0) ? LATCH : SHIFT;
      LATCH:   w_state_n = (r_cnt == LATCH_LAST) ? GAP : LATCH;
      GAP:     w_state_n = (r_cnt == GAP_LAST) ? (r_pend_v ? LOAD : IDLE) : GAP;
      default: w_state_n = IDLE;
    endcase
  end

  // a drained pending entry always wins the shift register; a coincident request refills pending
  assign w_start   = w_state_n == LOAD;
  assign w_pend_wr = iOU_en & (w_start ? r_pend_v : ~r_pend_v);
  assign w_drop    = iOU_en & ~w_start & r_pend_v;
  assign w_frame   = make_frame(r_pend_v ? r_pend : {iV_Address, iH_Duty});

  always_ff @(posedge iODCK or negedge iRST_n) begin
    if (!iRST_n) r_state <= IDLE;
    else r_state <= w_state_n;
  end

  always_ff @(posedge iODCK or negedge iRST_n) begin
    if (!iRST_n) begin
      r_pend   <= '0;
      r_pend_v <= 1'b0;
      r_shift  <= '0;
      r_sdi    <= 1'b0;
      r_bit    <= '0;
      r_cnt    <= '0;
      r_ovf    <= 1'b0;
    end else begin
      r_cnt    <= (w_state_n != r_state) ? '0 : r_cnt + 16'd1;
      r_pend_v <= w_pend_wr | (r_pend_v & ~w_start);
      r_ovf    <= w_drop | (r_ovf & ~iClrErr);
      if (w_pend_wr) r_pend <= {iV_Address, iH_Duty};
      // zeros shift in behind the frame, so SDI settles low for LATCH and GAP
      if (w_start) begin
        r_shift <= w_frame;
        r_sdi   <= w_frame[FRAME_W-1];
        r_bit   <= BIT_W'(FRAME_W - 1);
      end else if (w_fall) begin
        r_shift <= r_shift << 1;
        r_sdi   <= r_shift[FRAME_W-2];
        r_bit   <= r_bit - BIT_W'(1);
      end
    end
  end

  assign oSDI      = r_sdi;
  assign oLATCH    = r_state == LATCH;
  assign oBusy     = (r_state != IDLE) | r_pend_v;
  assign oOverflow = r_ovf;
endmodule

// File: tb/tb_backlight_out_tx.sv
// tb_backlight_out_tx: randomized scoreboard bench for backlight_out_tx at CLK_DIV=4 and CLK_DIV=1.
module tb_backlight_out_tx;
  localparam int CD0 = 4;
  localparam int CD1 = 1;
  localparam int GAPC = 8;
`ifdef BLT_PARITY_EN
  localparam int FW = 29;
`else
  localparam int FW = 28;
`endif
  localparam int T0 = 1 + FW * 2 * CD0 + 2 * CD0 + GAPC;
  localparam int T1 = 1 + FW * 2 * CD1 + 2 * CD1 + GAPC;

  typedef struct {
    logic [31:0] d;
    int          load;
  } exp_t;

  logic        iODCK = 1'b0;
  logic        rst_n = 1'b0;
  logic        en0 = 1'b0, en1 = 1'b0, clr0 = 1'b0;
  logic [3:0]  a0 = '0, a1 = '0;
  logic [23:0] d0 = '0, d1 = '0;
  wire  [1:0]  sclk, sdi, latch, busy, ovf;

  int          cyc = 0, checks = 0, errors = 0;
  exp_t        q0[$], q1[$];
  int          ll = -10, el = -10;
  logic        exp_ovf = 1'b0;
  int          nbits[2], last_rise[2], lat_start[2], nlatch[2];
  logic [31:0] bits[2], last_frame[2];
  logic [1:0]  psclk = '0, plat = '0;

  backlight_out_tx #(.CLK_DIV(CD0), .GAP_CYC(GAPC)) dut0 (
    .iODCK(iODCK), .iRST_n(rst_n), .iOU_en(en0), .iV_Address(a0), .iH_Duty(d0), .iClrErr(clr0),
    .oSCLK(sclk[0]), .oSDI(sdi[0]), .oLATCH(latch[0]), .oBusy(busy[0]), .oOverflow(ovf[0])
  );

  backlight_out_tx #(.CLK_DIV(CD1), .GAP_CYC(GAPC)) dut1 (
    .iODCK(iODCK), .iRST_n(rst_n), .iOU_en(en1), .iV_Address(a1), .iH_Duty(d1), .iClrErr(1'b0),
    .oSCLK(sclk[1]), .oSDI(sdi[1]), .oLATCH(latch[1]), .oBusy(busy[1]), .oOverflow(ovf[1])
  );

  always #5 iODCK = ~iODCK;
  always @(posedge iODCK) cyc <= cyc + 1;

  function automatic logic [31:0] mk(input logic [27:0] d);
`ifdef BLT_PARITY_EN
    return {3'b0, d, ^d};
`else
    return {4'b0, d};
`endif
  endfunction

  task automatic chk(input string nm, input longint act, input longint expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge iODCK);
      #1;
    end
  endtask

  // reference: a frame occupies LOAD..last GAP (T0 cycles); a pended request loads right after
  // the current frame's GAP, or one cycle later if it arrived on that last GAP cycle
  task automatic req0(input logic [3:0] a, input logic [23:0] d, input logic clr);
    int c;
    logic drop;
    exp_t e;
    @(posedge iODCK);
    #1;
    en0 = 1'b1; a0 = a; d0 = d; clr0 = clr;
    c = cyc;
    drop = 1'b0;
    e.d = mk({a, d});
    if (ll > c) begin
      if (c == ll - 1) ll = el + 1;
      else drop = 1'b1;
    end else if (c > el) ll = c + 1;
    else ll = (c < el) ? el + 1 : el + 2;
    if (!drop) begin
      el = ll + T0 - 1;
      e.load = ll;
      q0.push_back(e);
    end
    exp_ovf = drop | (exp_ovf & ~clr);
    @(posedge iODCK);
    #1;
    en0 = 1'b0; clr0 = 1'b0;
    chk("overflow", ovf[0], exp_ovf);
  endtask

  task automatic clr_pulse();
    @(posedge iODCK);
    #1;
    clr0 = 1'b1;
    exp_ovf = 1'b0;
    @(posedge iODCK);
    #1;
    clr0 = 1'b0;
    chk("overflow_clear", ovf[0], exp_ovf);
  endtask

  task automatic wait_idle(input int i, output int n);
    n = 0;
    @(negedge iODCK);
    while (busy[i] && n < 5000) begin
      n++;
      @(negedge iODCK);
    end
    chk("idle_bound", n < 5000, 1);
  endtask

  initial forever begin
    @(negedge iODCK);
    for (int i = 0; i < 2; i++) begin
      int cd, sz;
      exp_t e;
      cd = (i == 0) ? CD0 : CD1;
      if (!rst_n) begin
        nbits[i] = 0;
        bits[i] = '0;
      end else begin
        if (sclk[i] && !psclk[i]) begin
          if (nbits[i] > 0) chk("sclk_period", cyc - last_rise[i], 2 * cd);
          last_rise[i] = cyc;
          bits[i] = {bits[i][30:0], sdi[i]};
          nbits[i]++;
        end
        if (latch[i] && !plat[i]) begin
          lat_start[i] = cyc;
          nlatch[i]++;
          sz = (i == 0) ? q0.size() : q1.size();
          chk("frame_queued", sz > 0, 1);
          if (sz > 0) begin
            if (i == 0) e = q0.pop_front();
            else e = q1.pop_front();
            chk("frame_bits", nbits[i], FW);
            chk("frame_data", bits[i], e.d);
            chk("latch_time", cyc, e.load + 1 + FW * 2 * cd);
          end
          last_frame[i] = bits[i];
          nbits[i] = 0;
          bits[i] = '0;
        end
        if (!latch[i] && plat[i]) chk("latch_width", cyc - lat_start[i], 2 * cd);
      end
      psclk[i] = sclk[i];
      plat[i] = latch[i];
    end
  end

  initial begin
    #700000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int n, nl;
    exp_t e;
    tick(3);
    chk("reset_state0", {sclk[0], sdi[0], latch[0], busy[0], ovf[0]}, 0);
    chk("reset_state1", {sclk[1], sdi[1], latch[1], busy[1], ovf[1]}, 0);
    rst_n = 1'b1;
    tick(2);

    req0(4'hA, 24'h123456, 1'b0);
    wait_idle(0, n);
    chk("single_busy_span", n, T0);
    chk("single_frame_value", last_frame[0], mk(28'hA123456));

    req0(4'hA, 24'h123456, 1'b0);
    tick(18);
    req0(4'h1, 24'hFFFFFF, 1'b0);
    wait_idle(0, n);
    chk("b2b_busy_span", n, 2 * T0 - 20);

    req0(4'h1, 24'h111111, 1'b0);
    tick(30);
    req0(4'h2, 24'h222222, 1'b0);
    tick(30);
    req0(4'h3, 24'h333333, 1'b0);
    wait_idle(0, n);
    chk("overflow_sticky", ovf[0], 1);
    clr_pulse();
    req0(4'h4, 24'h444444, 1'b0);
    tick(20);
    req0(4'h5, 24'h555555, 1'b0);
    tick(20);
    req0(4'h6, 24'h666666, 1'b1);
    wait_idle(0, n);
    clr_pulse();

    for (int k = 0; k < 30; k++) begin
      logic [27:0] r;
      r = 28'($urandom);
      tick($urandom_range(0, 260));
      req0(r[27:24], r[23:0], $urandom_range(0, 5) == 0);
    end
    wait_idle(0, n);
    clr_pulse();

    req0(4'h0, 24'h000001, 1'b0);
    wait_idle(0, n);
`ifdef BLT_PARITY_EN
    chk("parity_one", last_frame[0][0], 1);
`endif
    req0(4'h0, 24'h000003, 1'b0);
    wait_idle(0, n);
`ifdef BLT_PARITY_EN
    chk("parity_zero", last_frame[0][0], 0);
`endif

    req0(4'hF, 24'hFFFFFF, 1'b0);
    n = 0;
    while (nbits[0] < 10 && n < 2000) begin
      @(negedge iODCK);
      n++;
    end
    chk("reach_bit10", n < 2000, 1);
    rst_n = 1'b0;
    #1;
    chk("reset_midframe", {sclk[0], sdi[0], latch[0], busy[0], ovf[0]}, 0);
    q0.delete();
    ll = -10; el = -10; exp_ovf = 1'b0;
    nl = nlatch[0];
    tick(3);
    rst_n = 1'b1;
    tick(300);
    chk("no_latch_after_reset", nlatch[0], nl);
    req0(4'h7, 24'hC3A5F0, 1'b0);
    wait_idle(0, n);
    chk("post_reset_span", n, T0);

    @(posedge iODCK);
    #1;
    en1 = 1'b1; a1 = 4'h5; d1 = 24'hAAAAAA;
    e.d = mk(28'h5AAAAAA);
    e.load = cyc + 1;
    q1.push_back(e);
    @(posedge iODCK);
    #1;
    en1 = 1'b0;
    wait_idle(1, n);
    chk("div1_busy_span", n, T1);
    chk("div1_frame_value", last_frame[1], mk(28'h5AAAAAA));

    chk("frames_outstanding0", q0.size(), 0);
    chk("frames_outstanding1", q1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
